// File: rtl/fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// fifo_rr_sched
//   Shares one synchronous, non-FWFT FIFO (1-cycle read latency) between NREQ
//   packet writers. The write side grants one requester at a time in round-robin
//   order and holds that grant until the packet's last beat is accepted. The read
//   side turns the FIFO read port into a valid/ready stream through a 2-entry
//   buffer, so the stream can run at one beat per cycle.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester beat valid
//   req_data      requester i drives bits [i*DATA_W +: DATA_W]
//   req_last      per-requester last-beat flag
//   req_ready     per-requester beat accept
//   fifo_din      {last, data} written to the FIFO
//   fifo_wr_en    FIFO write enable
//   fifo_full     FIFO full
//   fifo_rd_en    FIFO read enable
//   fifo_dout     FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty    FIFO empty
//   out_valid     output stream valid
//   out_data      output stream payload
//   out_last      output stream last-beat flag
//   out_ready     output stream ready from downstream
//   grant_id      requester that owns the lock (meaningful while busy=1)
//   busy          a packet is locked in progress
// -----------------------------------------------------------------------------
module fifo_rr_sched #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int IDW    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic [NREQ-1:0]        req_last,
   output logic [NREQ-1:0]        req_ready,
   output logic [DATA_W:0]        fifo_din,
   output logic                   fifo_wr_en,
   input  logic                   fifo_full,
   output logic                   fifo_rd_en,
   input  logic [DATA_W:0]        fifo_dout,
   input  logic                   fifo_empty,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } wr_state_t;

   wr_state_t          state_r;
   logic [IDW-1:0]     grant_id_r;
   logic [IDW-1:0]     last_grant_r;
   logic [IDW-1:0]     winner_s;
   logic               sel_valid_s;
   logic               sel_last_s;
   logic [DATA_W-1:0]  sel_data_s;
   logic [NREQ-1:0]    req_ready_s;

   logic [1:0]         occ_r;
   logic               infl_r;
   logic [DATA_W:0]    buf0_r;
   logic [DATA_W:0]    buf1_r;
   logic               pop_s;
   logic [2:0]         need_s;

   // First valid requester strictly after 'last', wrapping around.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
      logic [IDW-1:0] pick;
      logic           found;
      int             idx;
      pick  = {IDW{1'b0}};
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!found && valid[idx]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Round-robin winner for the next packet.
   always_comb begin
      winner_s = rr_pick(req_valid, last_grant_r);
   end

   // Route the granted requester's beat onto the FIFO write port.
   always_comb begin
      sel_valid_s = req_valid[grant_id_r];
      sel_last_s  = req_last[grant_id_r];
      sel_data_s  = req_data[int'(grant_id_r)*DATA_W +: DATA_W];
   end

   // Only the locked requester sees ready, and only while the FIFO has room.
   always_comb begin
      req_ready_s = {NREQ{1'b0}};
      if (state_r == ST_LOCK && !fifo_full) begin
         req_ready_s[grant_id_r] = 1'b1;
      end else begin
         req_ready_s = {NREQ{1'b0}};
      end
   end

   assign req_ready  = req_ready_s;
   assign fifo_wr_en = (state_r == ST_LOCK) && sel_valid_s && !fifo_full;
   assign fifo_din   = {sel_last_s, sel_data_s};
   assign busy       = (state_r == ST_LOCK);
   assign grant_id   = grant_id_r;

   // Write-side lock FSM: arbitrate in IDLE, hold the grant until last is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         grant_id_r   <= {IDW{1'b0}};
         last_grant_r <= IDW'(NREQ - 1);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|req_valid) begin
                  state_r    <= ST_LOCK;
                  grant_id_r <= winner_s;
               end
            end
            ST_LOCK: begin
               if (fifo_wr_en && sel_last_s) begin
                  state_r      <= ST_IDLE;
                  last_grant_r <= grant_id_r;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Read only when the buffer is guaranteed a free slot for the returning word,
   // counting the word already in flight and the slot freed by this cycle's pop.
   always_comb begin
      pop_s      = (occ_r != 2'd0) && out_ready;
      need_s     = {1'b0, occ_r} + {2'b00, infl_r} - {2'b00, pop_s};
      fifo_rd_en = !fifo_empty && (need_s < 3'd2);
   end

   // Two-entry output buffer; buf0_r is always the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r  <= 2'd0;
         infl_r <= 1'b0;
         buf0_r <= {(DATA_W+1){1'b0}};
         buf1_r <= {(DATA_W+1){1'b0}};
      end else begin
         infl_r <= fifo_rd_en;
         case ({infl_r, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  buf0_r <= fifo_dout;
               end else begin
                  buf1_r <= fifo_dout;
               end
               occ_r <= occ_r + 2'd1;
            end
            2'b01: begin
               buf0_r <= buf1_r;
               occ_r  <= occ_r - 2'd1;
            end
            2'b11: begin
               // Push and pop together: occupancy holds, new word goes behind.
               if (occ_r == 2'd1) begin
                  buf0_r <= fifo_dout;
               end else begin
                  buf0_r <= buf1_r;
                  buf1_r <= fifo_dout;
               end
            end
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign out_valid = (occ_r != 2'd0);
   assign out_data  = buf0_r[DATA_W-1:0];
   assign out_last  = buf0_r[DATA_W];

endmodule

// File: tb/tb_fifo_rr_sched.sv
module tb_fifo_rr_sched;
   localparam int NREQ   = 4;
   localparam int DATA_W = 8;
   localparam int IDW    = 2;
   localparam int DEPTH  = 16;

   typedef logic [DATA_W:0] beat_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        req_ready;
   logic [DATA_W:0]        fifo_din;
   logic                   fifo_wr_en;
   logic                   fifo_full;
   logic                   fifo_rd_en;
   logic [DATA_W:0]        fifo_dout = '0;
   logic                   fifo_empty;
   logic                   out_valid;
   logic [DATA_W-1:0]      out_data;
   logic                   out_last;
   logic                   out_ready = 1'b1;
   logic [IDW-1:0]         grant_id;
   logic                   busy;

   always #5 clk = ~clk;

   fifo_rr_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .grant_id(grant_id), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural my_fifo ----------------
   beat_t fq[$];
   int    fcount = 0;
   logic  force_full = 1'b0;
   assign fifo_empty = (fcount == 0);
   assign fifo_full  = force_full || (fcount >= DEPTH);

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            fq.delete();
            fcount    <= 0;
            fifo_dout <= '0;
         end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_din);
            fcount <= fq.size();
         end
      end
   end

   // ---------------- requester drivers ----------------
   beat_t           tq[NREQ][$];
   logic [NREQ-1:0] fire;

   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (fire[i] && tq[i].size() > 0) void'(tq[i].pop_front());
         end
         for (int i = 0; i < NREQ; i++) begin
            if (tq[i].size() > 0) begin
               req_valid[i] = 1'b1;
               req_data[i*DATA_W +: DATA_W] = tq[i][0][DATA_W-1:0];
               req_last[i] = tq[i][0][DATA_W];
            end else begin
               req_valid[i] = 1'b0;
               req_data[i*DATA_W +: DATA_W] = '0;
               req_last[i] = 1'b0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   beat_t sb[$];
   int    wr_log[$];
   int    gnt_log[$];
   logic  busy_q = 1'b0;
   int    occ_m  = 0;
   int    infl_m = 0;
   bit    chk_t3 = 1'b0;

   initial begin
      beat_t exp_b;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check((out_valid == (occ_m != 0)) && occ_m <= 2, "occupancy", occ_m, 2);
            check(!(fifo_rd_en && fifo_empty), "rd_en_while_empty", int'(fifo_rd_en), 0);
            check(!(fifo_wr_en && fifo_full), "wr_en_while_full", int'(fifo_wr_en), 0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check(1'b0, "unexpected_out", int'({out_last, out_data}), 0);
               end else begin
                  exp_b = sb.pop_front();
                  check({out_last, out_data} == exp_b, "out_beat", int'({out_last, out_data}), int'(exp_b));
               end
            end
            if (chk_t3 && req_valid[1] && tq[0].size() != 0)
               check(req_ready[1] == 1'b0, "req1_ready_during_req0", int'(req_ready[1]), 0);
            if (fifo_wr_en) wr_log.push_back(cyc);
            if (busy && !busy_q) gnt_log.push_back(int'(grant_id));
            occ_m  = occ_m + infl_m - ((out_valid && out_ready) ? 1 : 0);
            infl_m = fifo_rd_en ? 1 : 0;
            busy_q = busy;
         end else begin
            occ_m  = 0;
            infl_m = 0;
            busy_q = 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      for (int i = 0; i < NREQ; i++) tq[i].delete();
      sb.delete();
      step();
      rst = 1'b0;
      wr_log.delete();
      gnt_log.delete();
   endtask

   function automatic bit all_idle();
      bit r;
      r = (sb.size() == 0);
      for (int i = 0; i < NREQ; i++) if (tq[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic drain(input string name, input int bound);
      int k;
      k = 0;
      while (!all_idle() && k < bound) begin
         step();
         k++;
      end
      check(all_idle(), name, sb.size(), 0);
   endtask

   task automatic push_pkt(input int r, input int first, input int n, input bit expect_out);
      beat_t b;
      for (int j = 0; j < n; j++) begin
         b = {(j == n - 1) ? 1'b1 : 1'b0, 8'(first + j)};
         tq[r].push_back(b);
         if (expect_out) sb.push_back(b);
      end
   endtask

   task automatic check_spacing(input string name, input int n, input int gap);
      check(wr_log.size() == n, {name, "_count"}, wr_log.size(), n);
      for (int j = 1; j < wr_log.size(); j++)
         check(wr_log[j] - wr_log[j-1] == gap, {name, "_gap"}, wr_log[j] - wr_log[j-1], gap);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int k;
      int pat[4];
      int exp_g[5];
      pat   = '{1, 0, 0, 1};
      exp_g = '{0, 1, 2, 3, 0};

      // 1: reset values, then a 3-beat packet from requester 0
      do_reset();
      @(negedge clk);
      check({req_ready, fifo_wr_en, fifo_rd_en, out_valid, busy, grant_id} == '0,
            "reset_outputs", int'({req_ready, fifo_wr_en, fifo_rd_en, out_valid, busy, grant_id}), 0);
      tq[0].push_back({1'b0, 8'h11});
      tq[0].push_back({1'b0, 8'h22});
      tq[0].push_back({1'b1, 8'h33});
      sb.push_back({1'b0, 8'h11});
      sb.push_back({1'b0, 8'h22});
      sb.push_back({1'b1, 8'h33});
      step();
      @(negedge clk);
      check(busy == 1'b0, "busy_during_arb", int'(busy), 0);
      step();
      @(negedge clk);
      check(busy == 1'b1 && grant_id == 2'd0, "busy_after_arb", int'({busy, grant_id}), 4);
      drain("t1_drain", 50);
      check_spacing("t1_writes", 3, 1);

      // 2: four single-beat packets, requester 0 has a second one
      do_reset();
      push_pkt(0, 'hA0, 1, 1'b1);
      push_pkt(1, 'hB1, 1, 1'b1);
      push_pkt(2, 'hC2, 1, 1'b1);
      push_pkt(3, 'hD3, 1, 1'b1);
      push_pkt(0, 'hE0, 1, 1'b1);
      drain("t2_drain", 80);
      check(gnt_log.size() == 5, "t2_grant_count", gnt_log.size(), 5);
      for (int j = 0; j < 5 && j < gnt_log.size(); j++)
         check(gnt_log[j] == exp_g[j], "t2_grant_order", gnt_log[j], exp_g[j]);
      check_spacing("t2_writes", 5, 2);

      // 3: requester 1 waits for requester 0's whole packet
      do_reset();
      chk_t3 = 1'b1;
      push_pkt(0, 'h40, 4, 1'b1);
      push_pkt(1, 'h50, 1, 1'b1);
      drain("t3_drain", 80);
      chk_t3 = 1'b0;
      check(gnt_log.size() == 2 && gnt_log[0] == 0 && gnt_log[1] == 1,
            "t3_grants", gnt_log.size(), 2);

      // 4: FIFO full for 5 cycles mid-packet
      do_reset();
      push_pkt(0, 'h60, 6, 1'b1);
      k = 0;
      while (tq[0].size() > 4 && k < 20) begin
         step();
         k++;
      end
      check(tq[0].size() == 4, "t4_wait_two_beats", tq[0].size(), 4);
      force_full = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check(req_ready == '0 && fifo_wr_en == 1'b0, "t4_stall",
               int'({req_ready, fifo_wr_en}), 0);
         step();
      end
      force_full = 1'b0;
      drain("t4_drain", 80);

      // 5: 10-beat stream with out_ready toggling 1,0,0,1
      do_reset();
      push_pkt(2, 'h70, 10, 1'b1);
      for (int j = 0; j < 40; j++) begin
         out_ready = (pat[j % 4] != 0);
         step();
      end
      out_ready = 1'b1;
      drain("t5_drain", 80);

      // 6: reset during beat 2 of a 4-beat packet
      do_reset();
      push_pkt(0, 'h80, 4, 1'b0);
      k = 0;
      while (tq[0].size() > 3 && k < 20) begin
         step();
         k++;
      end
      check(tq[0].size() == 3, "t6_wait_first_beat", tq[0].size(), 3);
      rst = 1'b1;
      step();
      @(negedge clk);
      check({req_ready, fifo_wr_en, fifo_rd_en, out_valid, busy, grant_id} == '0,
            "t6_reset_outputs", int'({req_ready, fifo_wr_en, fifo_rd_en, out_valid, busy, grant_id}), 0);
      step();
      for (int i = 0; i < NREQ; i++) tq[i].delete();
      gnt_log.delete();
      rst = 1'b0;
      push_pkt(1, 'h90, 1, 1'b0);
      push_pkt(0, 'h91, 1, 1'b0);
      sb.push_back({1'b1, 8'h91});
      sb.push_back({1'b1, 8'h90});
      drain("t6_drain", 60);
      check(gnt_log.size() >= 1 && gnt_log[0] == 0, "t6_first_grant",
            (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
